io_input_filter: RTL and testbench

Input-conditioning stage in front of the single-cycle RV32I core. Synchronizes the raw board switches and push-buttons into `i_clk` and debounces every bit on a shared sample tick. Delivers clean, polarity-normalized levels plus one-cycle press/release pulses. Its outputs drive the core's switch and button inputs, which the LSU reads as memory-mapped I/O.

---
 rtl/io_input_filter.sv | 111 +++++++++++
 tb/tb_io_input_filter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_filter.sv
// io_input_filter: two-flop synchronizer, shared sample-tick prescaler and a
// per-bit N-sample debouncer for 32 slide switches and 4 push-buttons.
// Buttons are normalized so that o_btn reads 1 while pressed.
module io_input_filter #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned STABLE_TICKS   = 4,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  output logic [31:0] o_sw,
  output logic [3:0]  o_btn,
  output logic [3:0]  o_btn_press,
  output logic [3:0]  o_btn_release,
  output logic        o_tick
);

  localparam int unsigned NB = 36;
  localparam int unsigned HD = STABLE_TICKS - 1;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  // Idle raw level per bit: switches idle at 0, buttons at their released level.
  localparam logic [NB-1:0] IDLE = {{4{BTN_ACTIVE_LOW}}, 32'h0};
  // Polarity mask turning raw button levels into "1 = pressed".
  localparam logic [3:0] BTN_POL = {4{BTN_ACTIVE_LOW}};

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [NB-1:0] hist [HD];
  logic [NB-1:0] stable;
  logic [NB-1:0] all_one;
  logic [NB-1:0] all_zero;
  logic [NB-1:0] upd;
  logic [3:0]    btn_new;
  logic [3:0]    press;
  logic [3:0]    release_q;

  assign raw = {i_btn_raw, i_sw_raw};

  // Two-stage synchronizer for every raw input bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Sample-tick prescaler counting 0..TICK_DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

  // Window agreement: current sample plus every history entry all 1 or all 0.
  always_comb begin
    all_one  = sync2;
    all_zero = ~sync2;
    for (int unsigned i = 0; i < HD; i++) begin
      all_one  = all_one & hist[i];
      all_zero = all_zero & ~hist[i];
    end
    upd     = {NB{tick}} & (all_one | all_zero) & (sync2 ^ stable);
    btn_new = sync2[NB-1:32] ^ BTN_POL;
  end

  // History shift, stable level update and one-cycle press/release pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < HD; i++) begin
        hist[i] <= IDLE;
      end
      stable    <= IDLE;
      press     <= '0;
      release_q <= '0;
    end else begin
      if (tick) begin
        for (int unsigned i = HD - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
        end
        hist[0] <= sync2;
      end
      // Updating bits take the sampled value, which is the inverse of stable.
      stable    <= stable ^ upd;
      press     <= upd[NB-1:32] & btn_new;
      release_q <= upd[NB-1:32] & ~btn_new;
    end
  end

  assign o_sw          = stable[31:0];
  assign o_btn         = stable[NB-1:32] ^ BTN_POL;
  assign o_btn_press   = press;
  assign o_btn_release = release_q;
  assign o_tick        = tick;

endmodule

// File: tb/tb_io_input_filter.sv
// tb_io_input_filter: directed plus random stimulus for io_input_filter.
// A run-length reference model predicts every output event; a monitor pops
// and compares whenever the DUT shows a level change or a pulse.
module tb_io_input_filter;

  localparam int unsigned TD  = 3;
  localparam int unsigned ST  = 4;
  localparam bit          BAL = 1'b1;
  localparam logic [35:0] IDLE = {{4{BAL}}, 32'h0};

  typedef struct {
    int         cyc;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [3:0]  press;
    logic [3:0]  rel;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [31:0] o_sw;
  logic [3:0]  o_btn;
  logic [3:0]  o_btn_press;
  logic [3:0]  o_btn_release;
  logic        o_tick;

  io_input_filter #(
    .TICK_DIV      (TD),
    .STABLE_TICKS  (ST),
    .BTN_ACTIVE_LOW(BAL)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_sw_raw     (sw_raw),
    .i_btn_raw    (btn_raw),
    .o_sw         (o_sw),
    .o_btn        (o_btn),
    .o_btn_press  (o_btn_press),
    .o_btn_release(o_btn_release),
    .o_tick       (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (written only by the model process).
  int          cyc = 0;
  logic [35:0] m_s1, m_s2, m_lv, m_stable;
  int          m_run [36];
  int          m_cnt;
  logic [3:0]  m_press, m_rel;
  logic [31:0] pe_sw = '0;
  logic [3:0]  pe_btn = '0;
  logic        exp_tick;
  logic        m_in_reset;
  logic        tk;
  logic [35:0] s;
  ev_t         q[$];

  // Scoreboard counters (written only by the monitor).
  int errors = 0;
  int checks = 0;
  bit done = 1'b0;
  bit reported = 1'b0;
  logic [31:0] pd_sw = '0;
  logic [3:0]  pd_btn = '0;

  // Model: a bit adopts a new level once STABLE_TICKS consecutive tick
  // samples of the synchronized input agree on it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_s1 = IDLE;
      m_s2 = IDLE;
      m_cnt = 0;
      m_lv = IDLE;
      for (int i = 0; i < 36; i++) m_run[i] = ST - 1;
      m_stable = IDLE;
      m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      tk = (m_cnt == TD - 1);
      s = m_s2;
      if (tk) begin
        for (int i = 0; i < 36; i++) begin
          if (s[i] == m_lv[i]) begin
            if (m_run[i] < ST) m_run[i] = m_run[i] + 1;
          end else begin
            m_lv[i] = s[i];
            m_run[i] = 1;
          end
          if (m_run[i] >= ST && s[i] != m_stable[i]) begin
            m_stable[i] = s[i];
            if (i >= 32) begin
              if ((s[i] ^ BAL) == 1'b1) m_press[i-32] = 1'b1;
              else m_rel[i-32] = 1'b1;
            end
          end
        end
      end
      m_cnt = tk ? 0 : m_cnt + 1;
      m_s2 = m_s1;
      m_s1 = {btn_raw, sw_raw};
    end
    exp_tick = (m_cnt == TD - 1);
    if (m_stable[31:0] != pe_sw || (m_stable[35:32] ^ {4{BAL}}) != pe_btn ||
        m_press != 0 || m_rel != 0) begin
      q.push_back('{cyc, m_stable[31:0], m_stable[35:32] ^ {4{BAL}}, m_press, m_rel});
    end
    pe_sw  = m_stable[31:0];
    pe_btn = m_stable[35:32] ^ {4{BAL}};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks tick and reset levels every cycle, and compares each DUT
  // output event against the oldest predicted event.
  always @(negedge clk) begin
    ev_t e;
    if (cyc > 0) begin
      chk("tick", 64'(o_tick), 64'(exp_tick));
      if (m_in_reset) begin
        chk("rst_sw", 64'(o_sw), 64'h0);
        chk("rst_btn", 64'(o_btn), 64'h0);
        chk("rst_press", 64'(o_btn_press), 64'h0);
        chk("rst_release", 64'(o_btn_release), 64'h0);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_event_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (o_sw != pd_sw || o_btn != pd_btn || o_btn_press != 0 || o_btn_release != 0) begin
        if (q.size() == 0) begin
          chk("unexpected_event_btn", 64'(o_btn), 64'(pd_btn));
          chk("unexpected_event_pulse", 64'({o_btn_press, o_btn_release}), 64'h0);
        end else begin
          e = q.pop_front();
          chk("ev_cycle", 64'(cyc), 64'(e.cyc));
          chk("ev_sw", 64'(o_sw), 64'(e.sw));
          chk("ev_btn", 64'(o_btn), 64'(e.btn));
          chk("ev_press", 64'(o_btn_press), 64'(e.press));
          chk("ev_release", 64'(o_btn_release), 64'(e.rel));
        end
      end
      pd_sw  = o_sw;
      pd_btn = o_btn;
      if (done && !reported) begin
        reported = 1'b1;
        chk("leftover_events", 64'(q.size()), 64'h0);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios followed by random bouncing and resets.
  initial begin
    rst = 1'b1;
    sw_raw = 32'hFFFF_FFFF;
    btn_raw = 4'hF;
    hold(3);
    rst = 1'b0;
    hold(40);
    // clean press and release of button 2
    btn_raw = 4'b1011;
    hold(30);
    btn_raw = 4'hF;
    hold(30);
    // bounce on button 0
    for (int i = 0; i < 15; i++) begin
      btn_raw[0] = ~btn_raw[0];
      hold(2);
    end
    btn_raw[0] = 1'b1;
    hold(30);
    // reset during accumulation of a button 1 press
    btn_raw = 4'b1101;
    hold(8);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(30);
    btn_raw = 4'hF;
    hold(30);
    // concurrent release of button 3 and press of button 1
    btn_raw = 4'b0111;
    hold(30);
    btn_raw = 4'b1101;
    hold(30);
    btn_raw = 4'hF;
    // multi-bit switch change
    sw_raw = 32'h0000_00A5;
    hold(30);
    // random phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) sw_raw = sw_raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) btn_raw = btn_raw ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        hold($urandom_range(1, 3));
        rst = 1'b0;
      end
      hold(($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : 1);
    end
    hold(40);
    done = 1'b1;
    hold(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
